// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side and SRAM-side signals of the MEM-stage data-memory controller.
// The controller takes the master view; the pipeline/SRAM environment takes the slave view.
interface sram_mem_ctrl_if #(
  parameter int unsigned SRAM_AW = 18
);
  logic               MEM_R_EN;
  logic               MEM_W_EN;
  logic [31:0]        ALU_Res;
  logic [31:0]        Val_Rm;
  logic               ready;
  logic [31:0]        Mem_Data;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic [15:0]        SRAM_WDATA;
  logic [15:0]        SRAM_RDATA;
  logic               SRAM_WE_N;

  modport master (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_RDATA,
    output ready, Mem_Data, SRAM_ADDR, SRAM_WDATA, SRAM_WE_N
  );

  modport slave (
    output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, SRAM_RDATA,
    input  ready, Mem_Data, SRAM_ADDR, SRAM_WDATA, SRAM_WE_N
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two 16-bit
// SRAM accesses (low half then high half), each lasting WAIT_CYCLES clocks.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no access; a request moves to LOW
//  LOW   | driving half-word {widx,0}, data bits [15:0]
//  HIGH  | driving half-word {widx,1}, data bits [31:16]
//  DONE  | one cycle, ready high so the pipeline advances; back to IDLE
module sram_mem_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic              clk,
  input  logic              rst,
  sram_mem_ctrl_if.master   bus
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        mem_data_q, mem_data_d;

  logic               req;
  logic               wr;
  logic               rd;
  logic               cnt_last;
  logic [31:0]        offs;
  logic [SRAM_AW-2:0] widx;
  logic               unused_offs;

  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic               sram_we_n;

  assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign wr       = bus.MEM_W_EN;
  // A simultaneous read+write is treated as a write, so it must not load Mem_Data.
  assign rd       = bus.MEM_R_EN & ~bus.MEM_W_EN;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Addresses below BASE_ADDR wrap through the unsigned subtract by design.
  assign offs        = bus.ALU_Res - 32'(BASE_ADDR);
  assign widx        = offs[SRAM_AW:2];
  assign unused_offs = &{1'b0, offs[31:SRAM_AW+1], offs[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end

      LOW: begin
        sram_addr  = {widx, 1'b0};
        sram_wdata = bus.Val_Rm[15:0];
        sram_we_n  = ~wr;
        if (cnt_last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (rd) mem_data_d[15:0] = bus.SRAM_RDATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HIGH: begin
        sram_addr  = {widx, 1'b1};
        sram_wdata = bus.Val_Rm[31:16];
        sram_we_n  = ~wr;
        if (cnt_last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (rd) mem_data_d[31:16] = bus.SRAM_RDATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Always returns to IDLE so a still-present request cannot retrigger from here.
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ready      = ~req | (state_q == DONE);
  assign bus.Mem_Data   = mem_data_q;
  assign bus.SRAM_ADDR  = sram_addr;
  assign bus.SRAM_WDATA = sram_wdata;
  assign bus.SRAM_WE_N  = sram_we_n;

endmodule
